fir_mac_sequencer: RTL and testbench
====================================

# fir_mac_sequencer

Time-multiplexed FIR controller. It accepts one signed sample per valid/ready handshake and stores it in an N-deep circular history buffer. It then drives a single shared multiply-accumulate unit through all N taps, one product per cycle, and presents the saturated result on a valid/ready output port. It replaces the fully parallel N-multiplier filter wherever throughput of one sample per N+2 cycles is sufficient. It also owns the runtime-writable coefficient bank.

## Interface
Parameters:
- N, 8, tap count; power of two, ≥2
- DW, 8, signed input sample width
- CW, 8, signed coefficient width
- OW, 16, signed output width
- AW, DW+CW+$clog2(N), internal accumulator width (derived, not overridable)

Ports:
- clk  in  1  rising-edge clock, sole clock domain
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  sample offered
- in_ready  out  1  sequencer can accept a sample
- in_data  in  DW  signed sample
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  OW  signed saturated filter output
- coef_we  in  1  coefficient write strobe
- coef_addr  in  $clog2(N)  tap index
- coef_data  in  CW  signed coefficient
- busy  out  1  high in MAC or OUT state

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - MAC: N cycles, tap counter k runs 0..N-1.
  - OUT: out_valid=1.
- Transitions:
  - IDLE→MAC on in_valid.
  - MAC→OUT when k==N-1.
  - OUT→IDLE on out_ready.
- Accept (IDLE & in_valid):
  - Write in_data to hist[wr_ptr].
  - Clear the accumulator.
  - Latch base=wr_ptr.
  - wr_ptr advances modulo N; it wraps from N-1 to 0.
- MAC cycle k: acc += hist[(base−k) mod N] * coef[k]. The product is a full-precision signed DW+CW value, sign-extended to AW. The accumulator never overflows.
- Entering OUT: out_data = acc saturated to signed OW range, clamping to [−2^(OW−1), 2^(OW−1)−1]. out_data holds stable while out_valid & !out_ready.
- Coefficients:
  - A write is honored only in IDLE. coef_we in MAC or OUT is ignored and dropped silently.
  - Simultaneous coef_we and sample accept in IDLE: both take effect, and the new coefficient applies to that sample's MAC pass.
- History holds the last N accepted samples; unwritten entries read as 0 after reset.
- busy = (state != IDLE).

## Timing
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, out_data=0, busy=0
  - wr_ptr=0, k=0, acc=0, all hist=0
  - coef = {2,5,12,22,22,12,5,2} when N=8; otherwise 0
- Sample accepted at edge T. MAC occupies cycles T+1..T+N. out_valid is high from cycle T+N+1.
- Throughput with out_ready tied high: one sample per N+2 cycles.
- in_ready is 0 throughout MAC and OUT, so no input buffering is needed.
- Backpressure: OUT persists indefinitely. in_ready stays 0 until the cycle after the out handshake.
- Reset asserted mid-MAC or mid-OUT:
  - Returns to reset values immediately and asynchronously.
  - The partial result is discarded; no out_valid is produced.
  - History and coefficients revert to their reset contents.

## Structure
- Package fir_pkg holds:
  - Default N/DW/CW/OW
  - Default coefficient array constant
  - FSM state enum (IDLE, MAC, OUT)
  - Saturation helper function
- Sub-module fir_mac_unit:
  - Inputs: sample, coefficient, clear, enable.
  - Output: AW-bit accumulator.
  - Keeps the multiplier isolated for later pipelining.
- Sequencer top-level holds the FSM, pointers, history regfile and coefficient regfile.

## Test plan
- Impulse: reset, then samples 1,0,0,0,0,0,0,0,0 with out_ready=1 → outputs 2,5,12,22,22,12,5,2,0. Each out_valid appears exactly N+1 cycles after its accept.
- Step saturation: write all coef=127, feed 127 repeatedly → outputs 16129, 32258, then 32767 clamped from the third sample on. Feed −128 ×8 → final output −32768.
- Backpressure: hold out_ready=0 for 5 cycles in OUT → out_data stable, in_ready=0, busy=1; the next sample is accepted only after the handshake.
- Coefficient write race:
  - coef_we (addr 0, data 10) in the same IDLE cycle as accepting impulse 1 → first output 10.
  - coef_we during MAC → ignored; coef[0] unchanged on readback via a later impulse.
- Reset mid-MAC: assert rst at MAC cycle 3 → out_valid never rises, in_ready=1 after release, the next impulse reproduces the default response.
- Wrap-around: stream 20 consecutive samples of value 1 → outputs settle at 82 (coefficient sum) from the 8th onward; wr_ptr wraps twice with no glitch.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared defaults, FSM encoding and saturation helper for the time-multiplexed FIR.
package fir_pkg;

    localparam int N_DEF  = 8;
    localparam int DW_DEF = 8;
    localparam int CW_DEF = 8;
    localparam int OW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    // Reset contents of the coefficient bank for the 8-tap build.
    function automatic int coef_default(input int i);
        case (i)
            0, 7:    return 2;
            1, 6:    return 5;
            2, 5:    return 12;
            3, 4:    return 22;
            default: return 0;
        endcase
    endfunction

    // Returns {above_max, below_min} of v against a signed ow-bit range.
    function automatic logic [1:0] sat_dir(input logic signed [63:0] v, input int ow);
        logic signed [63:0] mx;
        logic signed [63:0] mn;
        mx = (64'sd1 <<< (ow - 1)) - 64'sd1;
        mn = -mx - 64'sd1;
        return {v > mx, v < mn};
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Shared multiply-accumulate: one full-precision product per enabled cycle.
module fir_mac_unit
    import fir_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF,
    parameter int AW = DW + CW + 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] sample,
    input  logic signed [CW-1:0] coefficient,
    input  logic                 clear,
    input  logic                 enable,
    output logic signed [AW-1:0] acc
);

    logic signed [DW+CW-1:0] prod;
    logic signed [AW-1:0]    prod_ext;

    assign prod     = (DW+CW)'(sample) * (DW+CW)'(coefficient);
    assign prod_ext = {{(AW-DW-CW){prod[DW+CW-1]}}, prod};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         acc <= '0;
        else if (clear)  acc <= '0;
        else if (enable) acc <= acc + prod_ext;
    end

endmodule

// File: rtl/fir_mac_sequencer.sv
// FIR sequencer: history/coef regfiles and FSM stepping one shared MAC through N taps.
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF,
    parameter int OW = OW_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [DW-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [OW-1:0]   out_data,
    input  logic                   coef_we,
    input  logic [$clog2(N)-1:0]   coef_addr,
    input  logic signed [CW-1:0]   coef_data,
    output logic                   busy
);

    localparam int PW = $clog2(N);
    localparam int AW = DW + CW + PW;

    state_t               state, state_nx;
    logic [PW-1:0]        wr_ptr, base, k, rd_idx;
    logic signed [DW-1:0] hist [N];
    logic signed [CW-1:0] coef [N];
    logic signed [AW-1:0] acc;
    logic signed [63:0]   acc_ext;
    logic [1:0]           sat;
    logic                 accept;

    assign accept    = (state == IDLE) && in_valid;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)                state_nx = MAC;
            MAC:     if (k == PW'(N - 1))         state_nx = OUT;
            OUT:     if (out_ready)               state_nx = IDLE;
            default:                              state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            wr_ptr <= '0;
            base   <= '0;
            k      <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;   // N is a power of two, so this wraps N-1 -> 0
                base   <= wr_ptr;
                k      <= '0;
            end else if (state == MAC) begin
                k <= k + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) hist[i] <= '0;
        end else if (accept) begin
            hist[wr_ptr] <= in_data;
        end
    end

    // Writes land only while idle; a write in the accept cycle feeds that sample's pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++)
                coef[i] <= (N == 8) ? CW'(coef_default(i)) : '0;
        end else if ((state == IDLE) && coef_we) begin
            coef[coef_addr] <= coef_data;
        end
    end

    assign rd_idx = base - k;

    fir_mac_unit #(
        .DW(DW),
        .CW(CW),
        .AW(AW)
    ) u_mac (
        .clk        (clk),
        .rst        (rst),
        .sample     (hist[rd_idx]),
        .coefficient(coef[k]),
        .clear      (accept),
        .enable     (state == MAC),
        .acc        (acc)
    );

    // acc is frozen outside MAC, so the clamped view is stable for the whole OUT phase.
    assign acc_ext = {{(64-AW){acc[AW-1]}}, acc};
    assign sat     = sat_dir(acc_ext, OW);

    always_comb begin
        out_data = acc[OW-1:0];
        if (sat[1])      out_data = {1'b0, {(OW-1){1'b1}}};
        else if (sat[0]) out_data = {1'b1, {(OW-1){1'b0}}};
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with a cycle-level reference model and literal pins.
module tb_fir_mac_sequencer;

    localparam int N  = 8;
    localparam int DW = 8;
    localparam int CW = 8;
    localparam int OW = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] out_data;
    logic                 coef_we;
    logic [2:0]           coef_addr;
    logic signed [CW-1:0] coef_data;
    logic                 busy;

    fir_mac_sequencer #(.N(N), .DW(DW), .CW(CW), .OW(OW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model state
    int  mhist [N];
    int  mcoef [N];
    int  mwp, acyc, cyc;
    bit  pend;
    int  expq [$];
    int  got  [$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int defc(input int i);
        int t [8] = '{2, 5, 12, 22, 22, 12, 5, 2};
        return t[i];
    endfunction

    function automatic int clamp(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    // Model: each accepted sample yields the clamped dot product of the last N
    // samples (newest first) with the coefficients, visible N+1 cycles later.
    always @(negedge clk) begin
        bit     exp_ov;
        longint s;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                mhist[i] = 0;
                mcoef[i] = defc(i);
            end
            mwp  = 0;
            pend = 0;
            expq.delete();
        end
        exp_ov = pend && (cyc - acyc >= N + 1);
        chk("in_ready", in_ready, !pend);
        chk("out_valid", out_valid, exp_ov);
        chk("busy", busy, pend);
        if (rst) chk("rst_out_data", out_data, 0);
        if (exp_ov && expq.size() > 0) chk("out_data", out_data, expq[0]);
        if (!rst) begin
            if (exp_ov && out_ready) begin
                got.push_back(int'(out_data));
                if (expq.size() > 0) void'(expq.pop_front());
                pend = 0;
            end else if (!pend) begin
                if (coef_we) mcoef[coef_addr] = int'(coef_data);
                if (in_valid) begin
                    mhist[mwp] = int'(in_data);
                    s = 0;
                    for (int j = 0; j < N; j++)
                        s += longint'(mhist[(mwp - j + N) % N]) * longint'(mcoef[j]);
                    expq.push_back(clamp(s));
                    mwp  = (mwp + 1) % N;
                    pend = 1;
                    acyc = cyc;
                end
            end
        end
        cyc++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        got.delete();
    endtask

    task automatic send(input int v, input bit we = 0, input int addr = 0, input int cd = 0);
        int t = 0;
        in_valid  = 1'b1;
        in_data   = DW'(v);
        coef_we   = we;
        coef_addr = 3'(addr);
        coef_data = CW'(cd);
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        coef_we  = 1'b0;
    endtask

    task automatic wcoef(input int addr, input int cd);
        coef_we   = 1'b1;
        coef_addr = 3'(addr);
        coef_data = CW'(cd);
        tick(1);
        coef_we = 1'b0;
    endtask

    task automatic wait_got(input int n);
        int t = 0;
        while (got.size() < n && t < 500) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (got.size() < n) chk("output_timeout", got.size(), n);
    endtask

    function automatic int got_at(input int i);
        return (i < got.size()) ? got[i] : 32'h7fff_ffff;
    endfunction

    initial begin
        int imp [9] = '{2, 5, 12, 22, 22, 12, 5, 2, 0};
        int ramp [7] = '{2, 7, 19, 41, 63, 75, 80};
        int hold_v;
        int t;
        rst = 1'b1; in_valid = 0; in_data = '0; out_ready = 1'b1;
        coef_we = 0; coef_addr = '0; coef_data = '0;
        do_reset();

        // impulse response
        send(1);
        for (int i = 0; i < 8; i++) send(0);
        wait_got(9);
        for (int i = 0; i < 9; i++) chk($sformatf("impulse[%0d]", i), got_at(i), imp[i]);

        // coef write with accept applies; write during MAC is dropped
        do_reset();
        send(1, 1, 0, 10);
        tick(2);
        coef_we = 1; coef_addr = 3'd1; coef_data = 8'sd99;
        tick(1);
        coef_we = 0;
        send(0);
        wait_got(2);
        chk("race_first", got_at(0), 10);
        chk("race_ignored", got_at(1), 5);

        // reset in MAC cycle 3 discards the pass
        do_reset();
        send(1);
        tick(3);
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(20);
        chk("midmac_no_output", got.size(), 0);
        send(1);
        send(0);
        wait_got(2);
        chk("midmac_after0", got_at(0), 2);
        chk("midmac_after1", got_at(1), 5);

        // saturation
        do_reset();
        for (int i = 0; i < N; i++) wcoef(i, 127);
        for (int i = 0; i < 3; i++) send(127);
        wait_got(3);
        chk("sat0", got_at(0), 16129);
        chk("sat1", got_at(1), 32258);
        chk("sat2", got_at(2), 32767);
        for (int i = 0; i < 8; i++) send(-128);
        wait_got(11);
        chk("sat_neg", got_at(10), -32768);

        // backpressure: result held, next sample waits for handshake
        do_reset();
        out_ready = 1'b0;
        send(1);
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) chk("bp_timeout", 0, 1);
        hold_v   = int'(out_data);
        in_valid = 1'b1;
        in_data  = 8'sd7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_stable", out_data, hold_v);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_busy", busy, 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(7);
        wait_got(2);
        chk("bp_first", got_at(0), 2);
        chk("bp_second", got_at(1), 19);

        // wrap-around stream
        do_reset();
        for (int i = 0; i < 20; i++) send(1);
        wait_got(20);
        for (int i = 0; i < 20; i++)
            chk($sformatf("wrap[%0d]", i), got_at(i), (i < 7) ? ramp[i] : 82);

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
